// File: rtl/ahb_apb_bridge_nslv.sv
// AHB-Lite slave to APB3 master bridge: N one-hot decoded slaves, HSIZE check, optional PREADY timeout.
// Define AHB_APB_BRIDGE_APB4_EN to add the APB4 PSTRB/PPROT outputs.
module ahb_apb_bridge_nslv #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int N_SLV      = 4,
  parameter int SLV_SHIFT  = 12,
  parameter int TIMEOUT    = 0
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        HSEL,
  input  logic [HADDR_SIZE-1:0]       HADDR,
  input  logic [1:0]                  HTRANS,
  input  logic                        HWRITE,
  input  logic [2:0]                  HSIZE,
  input  logic [3:0]                  HPROT,
  input  logic [HDATA_SIZE-1:0]       HWDATA,
  input  logic                        HREADY,
  output logic                        HREADYOUT,
  output logic                        HRESP,
  output logic [HDATA_SIZE-1:0]       HRDATA,
  output logic [N_SLV-1:0]            PSEL,
  output logic                        PENABLE,
  output logic [HADDR_SIZE-1:0]       PADDR,
  output logic                        PWRITE,
  output logic [HDATA_SIZE-1:0]       PWDATA,
`ifdef AHB_APB_BRIDGE_APB4_EN
  output logic [HDATA_SIZE/8-1:0]     PSTRB,
  output logic [2:0]                  PPROT,
`endif
  input  logic [N_SLV*HDATA_SIZE-1:0] PRDATA,
  input  logic [N_SLV-1:0]            PREADY,
  input  logic [N_SLV-1:0]            PSLVERR,
  output logic [2:0]                  dbg_state_o
);

  localparam int IDXW     = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int MAX_SIZE = $clog2(HDATA_SIZE / 8);
  localparam int NSTRB    = HDATA_SIZE / 8;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_in, idx_q;
  logic [TW-1:0]           cnt_q;
  logic [HADDR_SIZE-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [HDATA_SIZE-1:0]   pwdata_q, hrdata_q, sel_rdata;
  logic [N_SLV-1:0]        sel_onehot;
  logic                    take, req_ok, sel_ready, sel_err, timeout_hit;

  // A transfer is taken only while the bridge shows HREADYOUT=1 (IDLE or ERR2) and the
  // bus-wide HREADY, HSEL and a NONSEQ/SEQ HTRANS are all high in the same cycle.
  assign take = HSEL & HREADY & HTRANS[1] & ((state_q == ST_IDLE) | (state_q == ST_ERR2));

  if (N_SLV > 1) begin : g_idx
    assign idx_in = HADDR[SLV_SHIFT +: IDXW];
  end else begin : g_idx_one
    assign idx_in = '0;
  end

  assign req_ok      = (32'(idx_in) < 32'(N_SLV)) && (32'(HSIZE) <= 32'(MAX_SIZE));
  assign sel_ready   = PREADY[idx_q];
  assign sel_err     = PSLVERR[idx_q];
  assign sel_rdata   = PRDATA[32'(idx_q) * HDATA_SIZE +: HDATA_SIZE];
  assign sel_onehot  = N_SLV'(1) << idx_q;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= TO_LAST);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (take) state_d = req_ok ? ST_SETUP : ST_ERR1;
        else      state_d = ST_IDLE;
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready)        state_d = sel_err ? ST_ERR1 : ST_IDLE;
        else if (timeout_hit) state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    PSEL      = '0;
    PENABLE   = 1'b0;
    case (state_q)
      ST_SETUP:  begin HREADYOUT = 1'b0; PSEL = sel_onehot; end
      ST_ACCESS: begin HREADYOUT = 1'b0; PSEL = sel_onehot; PENABLE = 1'b1; end
      ST_ERR1:   begin HREADYOUT = 1'b0; HRESP = 1'b1; end
      ST_ERR2:   HRESP = 1'b1;
      default:   ;
    endcase
  end

`ifdef AHB_APB_BRIDGE_APB4_EN
  localparam int LANE_W = (NSTRB > 1) ? $clog2(NSTRB) : 1;
  logic [NSTRB-1:0] strb_d, pstrb_q;
  logic [2:0]       pprot_q;
  logic [31:0]      nbytes, lane_base;
  logic             unused_in;

  // Little-endian lanes: a naturally aligned block of 2**HSIZE bytes at the address offset.
  always_comb begin
    nbytes    = 32'd1 << HSIZE;
    lane_base = 32'(HADDR[LANE_W-1:0]) & ~(nbytes - 32'd1);
    strb_d    = '0;
    for (int b = 0; b < NSTRB; b++)
      strb_d[b] = HWRITE && (32'(b) >= lane_base) && (32'(b) < lane_base + nbytes);
  end

  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;
  assign unused_in = ^{HTRANS[0], HPROT[3:2]};
`else
  logic unused_in;
  assign unused_in = ^{HTRANS[0], HPROT};
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
`ifdef AHB_APB_BRIDGE_APB4_EN
      pstrb_q  <= '0;
      pprot_q  <= '0;
`endif
    end else begin
      if (take && req_ok) begin
        paddr_q  <= HADDR;
        pwrite_q <= HWRITE;
        idx_q    <= idx_in;
`ifdef AHB_APB_BRIDGE_APB4_EN
        pstrb_q  <= strb_d;
        pprot_q  <= {~HPROT[0], 1'b0, HPROT[1]};
`endif
      end
      if (state_q == ST_SETUP) begin
        pwdata_q <= HWDATA;
        cnt_q    <= '0;
      end
      if (state_q == ST_ACCESS) begin
        if (cnt_q != TO_MAX) cnt_q <= cnt_q + TW'(1);
        if (sel_ready && !sel_err && !pwrite_q) hrdata_q <= sel_rdata;
      end
    end
  end

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign HRDATA      = hrdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_apb_bridge_nslv.sv
// Bench for ahb_apb_bridge_nslv: transaction tasks expand each AHB transfer into expected per-cycle outputs.
module tb_ahb_apb_bridge_nslv;
  localparam int AW = 32, DW = 32, NS = 4, TO = 8;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic HCLK = 1'b0, HRESETn;
  logic HSEL, HWRITE, HREADY, HREADYOUT, HRESP, PENABLE, PWRITE;
  logic [AW-1:0] HADDR, PADDR;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE, dbg_state;
  logic [3:0] HPROT;
  logic [DW-1:0] HWDATA, HRDATA, PWDATA;
  logic [NS-1:0] PSEL, PREADY, PSLVERR;
  logic [NS*DW-1:0] PRDATA;
`ifdef AHB_APB_BRIDGE_APB4_EN
  logic [3:0] PSTRB, last_pstrb;
  logic [2:0] PPROT, last_pprot;
`endif

  always #5 HCLK = ~HCLK;

  ahb_apb_bridge_nslv #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .N_SLV(NS), .SLV_SHIFT(12), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA),
`ifdef AHB_APB_BRIDGE_APB4_EN
    .PSTRB(PSTRB), .PPROT(PPROT),
`endif
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state_o(dbg_state));

  typedef struct packed {
    logic          hreadyout;
    logic          hresp;
    logic [NS-1:0] psel;
    logic          penable;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          chk_wdata;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] hrdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int total = 0, bad = 0;

  // model state: response owed in the next completion cycle, last completed read data
  logic          m_tail_resp;
  logic [DW-1:0] m_hrdata;
  logic [3:0]    cur_hprot;

  // run-length trackers used by the literal checks
  int low_run = 0, last_low_run = 0, pen_run = 0, last_pen_run = 0, resp_run = 0, last_resp_run = 0;
  logic [NS-1:0] last_psel;
  logic          psel_seen;
  logic [DW-1:0] last_pwdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (!HREADYOUT) low_run++; else if (low_run != 0) begin last_low_run = low_run; low_run = 0; end
      if (PENABLE) pen_run++; else if (pen_run != 0) begin last_pen_run = pen_run; pen_run = 0; end
      if (HRESP) resp_run++; else if (resp_run != 0) begin last_resp_run = resp_run; resp_run = 0; end
      if (PSEL != '0) begin
        last_psel = PSEL; psel_seen = 1'b1;
`ifdef AHB_APB_BRIDGE_APB4_EN
        last_pstrb = PSTRB; last_pprot = PPROT;
`endif
      end
      if (PENABLE && PWRITE) last_pwdata = PWDATA;
      if (exp_q.size() != 0) begin
        ce = exp_q.pop_front();
        chk("hreadyout", 64'(HREADYOUT), 64'(ce.hreadyout));
        chk("hresp", 64'(HRESP), 64'(ce.hresp));
        chk("psel", 64'(PSEL), 64'(ce.psel));
        chk("penable", 64'(PENABLE), 64'(ce.penable));
        chk("hrdata", 64'(HRDATA), 64'(ce.hrdata));
        if (ce.psel != '0) begin
          chk("paddr", 64'(PADDR), 64'(ce.paddr));
          chk("pwrite", 64'(PWRITE), 64'(ce.pwrite));
`ifdef AHB_APB_BRIDGE_APB4_EN
          chk("pstrb", 64'(PSTRB), 64'(ce.pstrb));
          chk("pprot", 64'(PPROT), 64'(ce.pprot));
`endif
        end
        if (ce.chk_wdata) chk("pwdata", 64'(PWDATA), 64'(ce.pwdata));
      end
    end
  end

  task automatic apb_idle();
    PREADY  = '1;
    PSLVERR = '1;
    PRDATA  = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
  endtask

  // wait-state cycle on AHB: HREADY low, a pending NONSEQ that must not be taken
  task automatic bus_wait();
    HSEL = 1'b1; HTRANS = T_NSEQ; HREADY = 1'b0; HADDR = 32'h0000_3FFC; HWRITE = 1'b1; HSIZE = 3'd2;
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.hreadyout = 1'b1;
    e.hresp     = m_tail_resp;
    e.hrdata    = m_hrdata;
    return e;
  endfunction

  task automatic idle(input logic hsel, input logic [1:0] trans);
    @(posedge HCLK); #1;
    HSEL = hsel; HTRANS = trans; HREADY = 1'b1; HADDR = 32'h0000_2000; HWRITE = 1'b0; HSIZE = 3'd2;
    HPROT = cur_hprot; apb_idle();
    exp_q.push_back(idle_exp());
    m_tail_resp = 1'b0;
  endtask

  task automatic xfer(input logic [1:0] trans, input logic [AW-1:0] addr, input logic wr,
                      input logic [2:0] size, input logic [DW-1:0] wdata, input int waits,
                      input logic slverr, input logic [DW-1:0] rdata);
    exp_t e;
    int idx, n, nb, base;
    logic tmo;
    logic [3:0] strb;
    idx = int'(addr[13:12]);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = trans; HREADY = 1'b1; HADDR = addr; HWRITE = wr; HSIZE = size;
    HPROT = cur_hprot; apb_idle();
    exp_q.push_back(idle_exp());
    m_tail_resp = 1'b0;
    if (size > 3'd2) begin
      @(posedge HCLK); #1;
      bus_wait(); HWDATA = wdata;
      e = '0; e.hresp = 1'b1; e.hrdata = m_hrdata;
      exp_q.push_back(e);
      m_tail_resp = 1'b1;
      return;
    end
    nb = 1 << size;
    base = int'(addr[1:0]) & ~(nb - 1);
    strb = '0;
    for (int b = 0; b < 4; b++) strb[b] = wr && (b >= base) && (b < base + nb);
    @(posedge HCLK); #1;
    bus_wait(); HWDATA = wdata;
    e = '0; e.psel = 4'(1 << idx); e.paddr = addr; e.pwrite = wr; e.hrdata = m_hrdata;
    e.pstrb = strb; e.pprot = {~cur_hprot[0], 1'b0, cur_hprot[1]};
    exp_q.push_back(e);
    tmo = (waits >= TO);
    n = tmo ? TO : waits + 1;
    for (int k = 0; k < n; k++) begin
      @(posedge HCLK); #1;
      bus_wait(); HWDATA = ~wdata;
      PREADY[idx] = (k == waits);
      PSLVERR[idx] = slverr;
      PRDATA[idx*DW +: DW] = rdata;
      e.penable = 1'b1; e.chk_wdata = wr; e.pwdata = wdata;
      exp_q.push_back(e);
    end
    if (tmo || slverr) begin
      @(posedge HCLK); #1;
      bus_wait(); apb_idle();
      e = '0; e.hresp = 1'b1; e.hrdata = m_hrdata;
      exp_q.push_back(e);
      m_tail_resp = 1'b1;
    end else if (!wr) begin
      m_hrdata = rdata;
    end
  endtask

  task automatic settle();
    idle(1'b0, T_IDLE);
    idle(1'b0, T_IDLE);
    @(negedge HCLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    exp_t e;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = T_IDLE; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0;
    HPROT = '0; HWDATA = '0; HREADY = 1'b1; apb_idle();
    m_tail_resp = 1'b0; m_hrdata = '0; cur_hprot = 4'b0000; psel_seen = 1'b0;
    last_psel = '0; last_pwdata = '0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", 64'(HREADYOUT), 64'(1));
    chk("rst_hresp", 64'(HRESP), 64'(0));
    chk("rst_hrdata", 64'(HRDATA), 64'(0));
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    chk("rst_pwrite", 64'(PWRITE), 64'(0));
    chk("rst_pwdata", 64'(PWDATA), 64'(0));
    HRESETn = 1'b1;

    // IDLE/BUSY with HSEL, and NONSEQ without HSEL: no APB activity
    idle(1'b1, T_BUSY); idle(1'b0, T_NSEQ); idle(1'b1, T_IDLE);
    settle();
    chk("no_psel_idle", 64'(psel_seen), 64'(0));

    // zero-wait write to slave 1
    xfer(T_NSEQ, 32'h0000_1004, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    settle();
    chk("t1_psel", 64'(last_psel), 64'(4'b0010));
    chk("t1_pwdata", 64'(last_pwdata), 64'(32'hDEAD_BEEF));
    chk("t1_low_cycles", 64'(last_low_run), 64'(2));

    // read slave 2, three wait states
    xfer(T_NSEQ, 32'h0000_2008, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'h1234_5678);
    settle();
    chk("t2_access_cycles", 64'(last_pen_run), 64'(4));
    chk("t2_hrdata", 64'(HRDATA), 64'(32'h1234_5678));
    chk("t2_low_cycles", 64'(last_low_run), 64'(5));
    chk("t2_psel", 64'(last_psel), 64'(4'b0100));

    // slave error on a SEQ read, then a write accepted during ERR2
    xfer(T_SEQ, 32'h0000_3000, 1'b0, 3'd2, 32'h0, 1, 1'b1, 32'hCAFE_F00D);
    xfer(T_NSEQ, 32'h0000_0020, 1'b1, 3'd2, 32'h0102_0304, 0, 1'b0, 32'h0);
    settle();
    chk("t3_resp_cycles", 64'(last_resp_run), 64'(2));
    chk("t3_hrdata_kept", 64'(HRDATA), 64'(32'h1234_5678));

    // PREADY stuck low: timeout after TO access cycles
    xfer(T_NSEQ, 32'h0000_0010, 1'b1, 3'd2, 32'h0000_55AA, 20, 1'b0, 32'h0);
    settle();
    chk("t4_access_cycles", 64'(last_pen_run), 64'(8));
    chk("t4_resp_cycles", 64'(last_resp_run), 64'(2));

    // oversize transfer: ERROR without any APB select
    psel_seen = 1'b0;
    xfer(T_NSEQ, 32'h0000_1000, 1'b0, 3'd3, 32'h0, 0, 1'b0, 32'h0);
    settle();
    chk("t4_size_no_psel", 64'(psel_seen), 64'(0));
    chk("t4_size_low_cycles", 64'(last_low_run), 64'(1));

    // byte read from slave 3 with one wait state
    xfer(T_NSEQ, 32'h0000_3002, 1'b0, 3'd0, 32'h0, 1, 1'b0, 32'h0000_00EE);
    settle();
    chk("byte_read_hrdata", 64'(HRDATA), 64'(32'h0000_00EE));

    // back-to-back write then read
    xfer(T_NSEQ, 32'h0000_2000, 1'b1, 3'd2, 32'h7777_1111, 0, 1'b0, 32'h0);
    xfer(T_NSEQ, 32'h0000_3004, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0BAD_C0DE);
    settle();
    chk("t5_hrdata", 64'(HRDATA), 64'(32'h0BAD_C0DE));

`ifdef AHB_APB_BRIDGE_APB4_EN
    cur_hprot = 4'b0011;
    xfer(T_NSEQ, 32'h0000_1003, 1'b1, 3'd0, 32'hAB00_0000, 0, 1'b0, 32'h0);
    settle();
    chk("t6_pstrb", 64'(last_pstrb), 64'(4'b1000));
    chk("t6_pprot", 64'(last_pprot), 64'(3'b001));
    cur_hprot = 4'b0000;
`endif

    // reset asserted during ACCESS
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = T_NSEQ; HREADY = 1'b1; HADDR = 32'h0000_1010; HWRITE = 1'b0; HSIZE = 3'd2;
    apb_idle();
    exp_q.push_back(idle_exp());
    @(posedge HCLK); #1;
    bus_wait();
    e = '0; e.psel = 4'b0010; e.paddr = 32'h0000_1010; e.hrdata = m_hrdata;
    exp_q.push_back(e);
    @(posedge HCLK); #1;
    bus_wait(); PREADY = '0;
    e.penable = 1'b1;
    exp_q.push_back(e);
    @(negedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    chk("t5_rst_psel", 64'(PSEL), 64'(0));
    chk("t5_rst_penable", 64'(PENABLE), 64'(0));
    chk("t5_rst_hreadyout", 64'(HREADYOUT), 64'(1));
    chk("t5_rst_hrdata", 64'(HRDATA), 64'(0));
    chk("t5_rst_paddr", 64'(PADDR), 64'(0));
    m_hrdata = '0; m_tail_resp = 1'b0;
    low_run = 0; pen_run = 0; resp_run = 0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    xfer(T_NSEQ, 32'h0000_0008, 1'b0, 3'd1, 32'h0, 0, 1'b0, 32'h0000_4321);
    settle();
    chk("post_rst_hrdata", 64'(HRDATA), 64'(32'h0000_4321));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
